// File: rtl/noc_inject_scheduler_pkg.sv
// rtl/noc_inject_scheduler_pkg.sv - shared flit width, valid-bit index and subnet ids
package noc_inject_scheduler_pkg;

    localparam int WIDTH_PORT = 24;
    localparam int VALID_BIT  = WIDTH_PORT - 1;

    localparam logic SUBNET1 = 1'b0;
    localparam logic SUBNET2 = 1'b1;

    typedef logic [WIDTH_PORT-1:0] flit_t;

endpackage

// File: rtl/noc_inject_scheduler_inj_fifo.sv
// rtl/noc_inject_scheduler_inj_fifo.sv - small circular FIFO holding core flits awaiting injection
module inj_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      count_q, count_d;
    logic             push_en, pop_en;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = mem_q[rd_q];
    assign count   = count_q;

    always_comb begin
        wr_d    = push_en ? wr_q + 1'b1 : wr_q;
        rd_d    = pop_en ? rd_q + 1'b1 : rd_q;
        count_d = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_q] <= push_data;
        end
    end

endmodule

// File: rtl/noc_inject_scheduler.sv
// rtl/noc_inject_scheduler.sv - steers queued core flits into the local port of one of two BLESS subnets
module noc_inject_scheduler
    import noc_inject_scheduler_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH_PORT-1:0] in_flit,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  inj_ok1,
    input  logic                  inj_ok2,
    input  logic [1:0]            en_mask,
    output logic [WIDTH_PORT-1:0] dinLocal1,
    output logic [WIDTH_PORT-1:0] dinLocal2,
    output logic                  starve,
    output logic [CNT_W-1:0]      inj_cnt1,
    output logic [CNT_W-1:0]      inj_cnt2
);

    localparam int          AW        = $clog2(DEPTH);
    localparam int          WW        = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT);

    logic          push, pop, fifo_full, fifo_empty;
    logic [AW:0]   fifo_count;
    flit_t         head;
    logic          elig1, elig2, grant1, grant2;

    logic          pref_q, pref_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          starve_q, starve_d;
    flit_t         din1_q, din1_d, din2_q, din2_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;

    // Readiness comes from the registered count only; a pop never frees a slot in its own cycle.
    assign in_ready = (fifo_count < DEPTH_CNT);
    assign push     = in_valid && in_ready && !fifo_full;

    inj_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH_PORT)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_flit),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        elig1  = inj_ok1 && en_mask[0] && !fifo_empty;
        elig2  = inj_ok2 && en_mask[1] && !fifo_empty;
        grant1 = elig1 && (pref_q == SUBNET1 || !elig2);
        grant2 = elig2 && (pref_q == SUBNET2 || !elig1);
        pop    = grant1 || grant2;

        pref_d = pref_q;
        if (grant1) begin
            pref_d = SUBNET2;
        end else if (grant2) begin
            pref_d = SUBNET1;
        end

        din1_d = grant1 ? head : '0;
        din2_d = grant2 ? head : '0;
        cnt1_d = cnt1_q + CNT_W'(grant1);
        cnt2_d = cnt2_q + CNT_W'(grant2);

        if (fifo_empty || pop) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = wait_q;
        end
        starve_d = (wait_q == WAIT_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pref_q   <= SUBNET1;
            wait_q   <= '0;
            starve_q <= 1'b0;
            din1_q   <= '0;
            din2_q   <= '0;
            cnt1_q   <= '0;
            cnt2_q   <= '0;
        end else begin
            pref_q   <= pref_d;
            wait_q   <= wait_d;
            starve_q <= starve_d;
            din1_q   <= din1_d;
            din2_q   <= din2_d;
            cnt1_q   <= cnt1_d;
            cnt2_q   <= cnt2_d;
        end
    end

    assign dinLocal1 = din1_q;
    assign dinLocal2 = din2_q;
    assign starve    = starve_q;
    assign inj_cnt1  = cnt1_q;
    assign inj_cnt2  = cnt2_q;

endmodule

// File: tb/tb_noc_inject_scheduler.sv
// tb/tb_noc_inject_scheduler.sv - randomized self-checking bench for noc_inject_scheduler
module tb_noc_inject_scheduler;
    import noc_inject_scheduler_pkg::*;

    localparam int DEPTH = 4;
    localparam int L     = 5;
    localparam int CW    = 4;
    localparam int VW    = 2 + 2 * WIDTH_PORT + 2 * CW;

    logic          clk = 1'b0;
    logic          reset;
    flit_t         in_flit;
    logic          in_valid;
    logic          in_ready;
    logic          inj_ok1, inj_ok2;
    logic [1:0]    en_mask;
    flit_t         d1, d2;
    logic          starve;
    logic [CW-1:0] c1, c2;
    logic [VW-1:0] dut_vec;

    int checks = 0;
    int errors = 0;

    flit_t mq[$];
    int    m_pref;
    int    m_wait;
    bit    m_starve;
    flit_t m_d1, m_d2;
    int    m_c1, m_c2;

    noc_inject_scheduler #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (L),
        .CNT_W        (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inj_ok1   (inj_ok1),
        .inj_ok2   (inj_ok2),
        .en_mask   (en_mask),
        .dinLocal1 (d1),
        .dinLocal2 (d2),
        .starve    (starve),
        .inj_cnt1  (c1),
        .inj_cnt2  (c2)
    );

    always #5 clk = ~clk;

    assign dut_vec = {in_ready, d1, d2, starve, c1, c2};

    task automatic model_reset();
        mq.delete();
        m_pref   = 1;
        m_wait   = 0;
        m_starve = 0;
        m_d1     = '0;
        m_d2     = '0;
        m_c1     = 0;
        m_c2     = 0;
    endtask

    // One clock edge of the reference: subnets are numbered 1 and 2, preferred one wins a tie.
    task automatic model_edge();
        int g;
        bit ne, rdy, e1, e2;
        ne  = (mq.size() > 0);
        rdy = (mq.size() < DEPTH);
        e1  = ne && inj_ok1 && en_mask[0];
        e2  = ne && inj_ok2 && en_mask[1];
        g   = 0;
        if (e1 && e2) g = m_pref;
        else if (e1)  g = 1;
        else if (e2)  g = 2;
        m_starve = (m_wait == L);
        if (!ne || g != 0) m_wait = 0;
        else if (m_wait < L) m_wait++;
        m_d1 = (g == 1) ? mq[0] : '0;
        m_d2 = (g == 2) ? mq[0] : '0;
        if (g != 0) begin
            void'(mq.pop_front());
            m_pref = 3 - g;
            if (g == 1) m_c1 = (m_c1 + 1) % (1 << CW);
            else        m_c2 = (m_c2 + 1) % (1 << CW);
        end
        if (in_valid && rdy) mq.push_back(in_flit);
    endtask

    function automatic logic [VW-1:0] model_vec();
        return {mq.size() < DEPTH, m_d1, m_d2, m_starve, CW'(m_c1), CW'(m_c2)};
    endfunction

    function automatic flit_t rnd_flit();
        flit_t f;
        f = flit_t'($urandom);
        f[VALID_BIT] = 1'b1;
        return f;
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [VW-1:0] exp_vec;
        reset = 1'b1; in_valid = 1'b0; in_flit = '0;
        inj_ok1 = 1'b0; inj_ok2 = 1'b0; en_mask = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        exp_vec = {1'b1, {WIDTH_PORT{1'b0}}, {WIDTH_PORT{1'b0}}, 1'b0, {CW{1'b0}}, {CW{1'b0}}};
        checks++;
        if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL reset_state got=%h exp=%h", dut_vec, exp_vec);
        end
        #3; reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_alternate();
        flit_t f[4];
        for (int i = 0; i < 4; i++) f[i] = rnd_flit();
        en_mask = 2'b11; inj_ok1 = 1'b1; inj_ok2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 4);
            in_flit  = (i < 4) ? f[i] : '0;
            step();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL alt_cycle%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
            if (i >= 1 && i <= 4) begin
                checks++;
                if ((((i - 1) % 2 == 0) ? d1 : d2) !== f[i-1]) begin
                    errors++; $display("FAIL alt_route%0d d1=%h d2=%h exp=%h", i - 1, d1, d2, f[i-1]);
                end
            end
        end
        checks++;
        if (c1 !== 4'd2 || c2 !== 4'd2) begin
            errors++; $display("FAIL alt_counts got=%0d/%0d exp=2/2", c1, c2);
        end
    endtask

    task automatic test_ok2_only();
        flit_t f[4];
        for (int i = 0; i < 4; i++) f[i] = rnd_flit();
        inj_ok1 = 1'b0; inj_ok2 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = (i < 3) || (i == 5);
            in_flit  = (i < 3) ? f[i] : ((i == 5) ? f[3] : '0);
            if (i == 5) inj_ok1 = 1'b1;
            step();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL ok2_cycle%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
            if (i >= 1 && i <= 3) begin
                checks++;
                if (d2 !== f[i-1] || d1 !== '0) begin
                    errors++; $display("FAIL ok2_route%0d d1=%h d2=%h exp_d2=%h", i - 1, d1, d2, f[i-1]);
                end
            end
            if (i == 3) begin
                checks++;
                if (c2 !== 4'd5) begin
                    errors++; $display("FAIL ok2_count got=%0d exp=5", c2);
                end
            end
        end
        checks++;
        if (d1 !== f[3]) begin
            errors++; $display("FAIL ok2_pref_kept d1=%h exp=%h", d1, f[3]);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_starve(output flit_t fs[4]);
        for (int i = 0; i < 4; i++) fs[i] = rnd_flit();
        en_mask = 2'b00; inj_ok1 = 1'b1; inj_ok2 = 1'b1;
        for (int i = 0; i <= L + 2; i++) begin
            in_valid = (i < 5);
            in_flit  = (i < 4) ? fs[i] : rnd_flit();
            step();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL stv_cycle%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
            checks++;
            if ((d1 | d2) !== '0) begin
                errors++; $display("FAIL stv_idle%0d d1=%h d2=%h exp=0", i, d1, d2);
            end
            if (i == 3) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL stv_full got=%b exp=0", in_ready);
                end
            end
            if (i == L || i == L + 1) begin
                checks++;
                if (starve !== (i == L + 1)) begin
                    errors++; $display("FAIL stv_rise%0d got=%b exp=%b", i, starve, i == L + 1);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_drain(input flit_t fs[4]);
        en_mask = 2'b01; inj_ok1 = 1'b1; inj_ok2 = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL drn_cycle%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
            if (i < 4) begin
                checks++;
                if (d1 !== fs[i]) begin
                    errors++; $display("FAIL drn_flit%0d got=%h exp=%h", i, d1, fs[i]);
                end
            end
            if (i < 2) begin
                checks++;
                if (starve !== (i == 0)) begin
                    errors++; $display("FAIL drn_starve%0d got=%b exp=%b", i, starve, i == 0);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        flit_t g;
        en_mask = 2'b11; inj_ok1 = 1'b0; inj_ok2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_flit = rnd_flit();
            step();
        end
        in_valid = 1'b0;
        #3; reset = 1'b1; #1;
        checks++;
        if (d1 !== '0 || d2 !== '0 || in_ready !== 1'b1 || c1 !== '0 || c2 !== '0 || starve !== 1'b0) begin
            errors++; $display("FAIL arst_immediate got=%h exp=%h", dut_vec,
                               {1'b1, {(VW-1){1'b0}}});
        end
        model_reset();
        #2; reset = 1'b0;
        g = rnd_flit();
        inj_ok1 = 1'b1; inj_ok2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = (i == 0);
            in_flit  = g;
            step();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL arst_cycle%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (c1 !== 4'd1 || c2 !== 4'd0) begin
            errors++; $display("FAIL arst_first_subnet cnt=%0d/%0d exp=1/0", c1, c2);
        end
    endtask

    task automatic test_wrap();
        reset = 1'b1; #2; model_reset(); reset = 1'b0;
        en_mask = 2'b01; inj_ok1 = 1'b1; inj_ok2 = 1'b1;
        for (int i = 0; i < 19; i++) begin
            in_valid = (i < 17);
            in_flit  = rnd_flit();
            step();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL wrap_cycle%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (c1 !== 4'd1) begin
            errors++; $display("FAIL wrap_count got=%0d exp=1", c1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid = $urandom_range(0, 3) != 0;
            in_flit  = rnd_flit();
            inj_ok1  = $urandom_range(0, 2) != 0;
            inj_ok2  = $urandom_range(0, 2) != 0;
            if (i % 50 == 0) en_mask = 2'($urandom_range(0, 3));
            step();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL rnd_cycle%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        flit_t fs[4];
        test_reset();
        test_alternate();
        test_ok2_only();
        test_starve(fs);
        test_drain(fs);
        test_async_reset();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
